multi_sprite_compositor: RTL
============================

// Module: multi_sprite_compositor
// PURPOSE
//  Parametrised successor of the single-sprite pixel colouriser. Composites up to NUM_SPRITES
//  bouncing sprites over a selectable background at COLOR_BITS per channel, with per-frame motion
//  and a frame tick both in the clk domain, plus transparency keying. Sits between the VGA timing
//  generator (hpos/vpos/visible) and the external sprite ROMs and pad drivers.
// PARAMETERS
//  NUM_SPRITES  4    sprites instantiated, 1..4; index 0 = highest priority
//  SPRITE_SIZE  64   sprite edge in pixels, power of two; AW = log2(SPRITE_SIZE)
//  COLOR_BITS   2    bits per R/G/B channel; CW = 3*COLOR_BITS
//  TRANSPARENT  0    CW-bit sprite colour treated as see-through
// PORTS
//  clk          in   1                       pixel clock
//  rst          in   1                       synchronous, active-high reset
//  hpos, vpos   in   10 each                 current beam position
//  visible      in   1                       beam inside active area
//  vga_control  in   8                       [7:6] op, [5:0] payload
//  sprite_addr  out  NUM_SPRITES*2*AW        slice i = {y_off[AW-1:0], x_off[AW-1:0]} of sprite i
//  sprite_rgb   in   NUM_SPRITES*CW          slice i = ROM data for sprite i, 1 clk after addr
//  R, G, B      out  COLOR_BITS each         composited pixel, registered
//  bounce_count out  4                       edge-hit counter, 0..10
// BEHAVIOUR
//  Frame tick: prev_vpos reg (reset 0); tick = (vpos==0 && prev_vpos!=0). No tick on the cycle after reset.
//  Sprite i reset: left = 32+96*i, top = 32+64*i, dx = +1, dy = i[0] ? +1 : -1.
//  On tick: left += dx, top += dy, computed with the pre-tick direction. Same cycle, per axis:
//   - if left == H_DISPLAY-SPRITE_SIZE-1 with dx=+1, flip dx;
//   - if left == 1 with dx=-1, flip dx;
//   - same rule for top against V_DISPLAY.
//   - Both axes may flip in one tick.
//  bounce_count: +1 per tick on which at least one edge hit occurs on any sprite (not one per hit).
//   Wraps 10 -> 0. Reset 0.
//  Pixel pipe. S0 (comb from hpos/vpos):
//   - dx_i = hpos-left_i, dy_i = vpos-top_i, 10-bit wrap;
//   - in_i = (dx_i[9:AW]==0 && dy_i[9:AW]==0);
//   - sprite_addr drives low AW bits of dy_i/dx_i (valid even when !in_i).
//  S1 (regs): in_i, visible, background colour bg.
//  S2 (regs): RGB = !visible_s1 ? 0 : colour of lowest i with in_i && sprite_rgb_i != TRANSPARENT, else bg.
//  RGB is therefore valid 2 clks after the hpos/vpos that produced it. R,G,B reset to 0.
//  Control (sampled every clk, reset: mode=0, solid = all ones):
//   - op0: solid <= payload;
//   - op1: hold;
//   - op2: mode <= payload[3:0];
//   - op3: mode <= bounce_count.
//  scroll: 10-bit counter, +1 per tick, wraps, reset 0.
//   - sx = hpos - scroll for modes 4,8,10, else hpos + scroll;
//   - sy = vpos - scroll for modes 6,9,10, else vpos + scroll.
//  Backgrounds, per channel c (0=R,1=G,2=B), MSB at bit 5+c of the stated coordinate:
//   - 0     solid colour;
//   - 1     MSB hpos[5+c], LSBs vpos[1];
//   - 2     MSB vpos[5+c], LSBs hpos[1];
//   - 3,4   MSB sx[5+c], LSBs vpos[2];
//   - 5,6   MSB sy[5+c], LSBs vpos[2];
//   - 7..10 MSB sy[5+c], LSBs sx[2];
//   - 11..15 treated as mode 0 (no latch inferred).
//   LSB bits of a channel replicate the stated bit when COLOR_BITS>2.
//  Reset mid-frame: all state returns to reset values on the next edge. Pipe outputs 0 until 2 clks after deassert.
// CONFIGURATION
//  SPRITE_COLLIDE_EN defined:
//   - extra output collision (1 bit, reset 0);
//   - set when in S2 two or more sprites are opaque at a visible pixel;
//   - sticky until the next tick. Tick and collision in the same cycle -> set wins.
//  Undefined: no collision port, no overlap logic.
// STRUCTURE
//  pixel_pkg: H_DISPLAY=640, V_DISPLAY=480, op encodings OP_SOLID/OP_HOLD/OP_MODE/OP_AUTO,
//   background mode constants, frame-tick helper function.
//  Sub-module sprite_mover: parameters SPRITE_SIZE, init left/top/dy. Inputs clk, rst, tick.
//   Outputs left, top, edge_hit. One instance per sprite via generate. Compositing stays in the top.
// TESTING
//  1 Reset, NUM_SPRITES=1: hold vpos=0 -> no tick. vpos 1->0 -> left 32->33, top 32->31.
//  2 Force sprite0 left=H_DISPLAY-SPRITE_SIZE-1, dx=+1, tick -> left=576, dx=-1, bounce_count +1.
//    Corner hit (both axes same tick) -> count +1 only.
//  3 Eleven hit ticks from reset -> bounce_count 0,1..10,0.
//    op3 then mirrors the count into mode.
//  4 Overlapping sprites 0 and 1 both opaque -> RGB = sprite0 colour, 2 clks after the pixel.
//    Sprite0 = TRANSPARENT -> sprite1 colour. Both transparent -> background.
//  5 op2 mode=4 with scroll=3: hpos=10 -> stripe from sx=7. visible=0 -> RGB=0 regardless.
//    op0 payload 6'b101010 -> mode0 RGB=10,10,10 (COLOR_BITS=2).
//  6 SPRITE_COLLIDE_EN: overlap pixel -> collision=1 and held; next tick -> 0.
//    Assert rst mid-line -> RGB 0 and positions back to init next clk.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared constants, control opcodes and frame-tick helper for the sprite compositor.
// Optional SPRITE_COLLIDE_EN support lives in multi_sprite_compositor.
package pixel_pkg;

  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;

  typedef enum logic [1:0] {
    OP_SOLID = 2'd0,
    OP_HOLD  = 2'd1,
    OP_MODE  = 2'd2,
    OP_AUTO  = 2'd3
  } op_e;

  localparam logic [3:0] BG_SOLID     = 4'd0;
  localparam logic [3:0] BG_HSTRIPE   = 4'd1;
  localparam logic [3:0] BG_VSTRIPE   = 4'd2;
  localparam logic [3:0] BG_SX_ADD    = 4'd3;
  localparam logic [3:0] BG_SX_SUB    = 4'd4;
  localparam logic [3:0] BG_SY_ADD    = 4'd5;
  localparam logic [3:0] BG_SY_SUB    = 4'd6;
  localparam logic [3:0] BG_XY_ADD    = 4'd7;
  localparam logic [3:0] BG_XY_SX_SUB = 4'd8;
  localparam logic [3:0] BG_XY_SY_SUB = 4'd9;
  localparam logic [3:0] BG_XY_SUB    = 4'd10;

  function automatic logic frame_tick(
    input logic [9:0] vpos,
    input logic [9:0] prev_vpos
  );
    return (vpos == 10'd0) && (prev_vpos != 10'd0);
  endfunction

endpackage

// File: rtl/sprite_mover.sv
// One bouncing sprite: position/direction state advanced once per frame tick.
// edge_hit flags a tick on which either axis reverses.
module sprite_mover
  import pixel_pkg::*;
#(
  parameter int         SPRITE_SIZE = 64,
  parameter logic [9:0] INIT_LEFT   = 10'd32,
  parameter logic [9:0] INIT_TOP    = 10'd32,
  parameter logic       INIT_DY_POS = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  output logic [9:0] left,
  output logic [9:0] top,
  output logic       edge_hit
);

  localparam logic [9:0] X_MAX = 10'(H_DISPLAY - SPRITE_SIZE - 1);
  localparam logic [9:0] Y_MAX = 10'(V_DISPLAY - SPRITE_SIZE - 1);

  logic dx_pos;
  logic dy_pos;
  logic hit_x;
  logic hit_y;

  assign hit_x = dx_pos ? (left == X_MAX) : (left == 10'd1);
  assign hit_y = dy_pos ? (top == Y_MAX) : (top == 10'd1);
  assign edge_hit = tick & (hit_x | hit_y);

  // step uses the pre-tick direction; the flip takes effect next tick
  always_ff @(posedge clk) begin
    if (rst) begin
      left   <= INIT_LEFT;
      top    <= INIT_TOP;
      dx_pos <= 1'b1;
      dy_pos <= INIT_DY_POS;
    end else if (tick) begin
      left <= dx_pos ? left + 10'd1 : left - 10'd1;
      top  <= dy_pos ? top + 10'd1 : top - 10'd1;
      if (hit_x) dx_pos <= ~dx_pos;
      if (hit_y) dy_pos <= ~dy_pos;
    end
  end

endmodule

// File: rtl/multi_sprite_compositor.sv
// Composites NUM_SPRITES bouncing sprites over a selectable background.
// Define SPRITE_COLLIDE_EN to add the sticky collision output.
module multi_sprite_compositor
  import pixel_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_SIZE = 64,
  parameter int COLOR_BITS  = 2,
  parameter logic [3*COLOR_BITS-1:0] TRANSPARENT = '0,
  localparam int AW = $clog2(SPRITE_SIZE),
  localparam int CW = 3 * COLOR_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [9:0]                  hpos,
  input  logic [9:0]                  vpos,
  input  logic                        visible,
  input  logic [7:0]                  vga_control,
  output logic [NUM_SPRITES*2*AW-1:0] sprite_addr,
  input  logic [NUM_SPRITES*CW-1:0]   sprite_rgb,
  output logic [COLOR_BITS-1:0]       R,
  output logic [COLOR_BITS-1:0]       G,
  output logic [COLOR_BITS-1:0]       B,
  output logic [3:0]                  bounce_count
`ifdef SPRITE_COLLIDE_EN
  ,
  output logic                        collision
`endif
);

  logic [9:0] prev_vpos;
  logic       tick;
  logic [9:0] scroll;
  logic [3:0] mode;
  logic [CW-1:0] solid;
  op_e        op;

  logic [9:0] left [NUM_SPRITES];
  logic [9:0] top  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hit;
  logic [NUM_SPRITES-1:0] in_s0;
  logic [NUM_SPRITES-1:0] in_s1;
  logic [NUM_SPRITES-1:0] opaque;
  logic          vis_s1;
  logic [CW-1:0] bg;
  logic [CW-1:0] bg_s1;
  logic [CW-1:0] pix;

  logic [9:0] sx;
  logic [9:0] sy;
  logic [9:0] coord;
  logic       lsb;
  logic       use_solid;
  logic       unused_bits;

  assign tick = frame_tick(vpos, prev_vpos);
  assign op = op_e'(vga_control[7:6]);
  assign unused_bits = ^{coord, vga_control};

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
    logic [9:0] off_x;
    logic [9:0] off_y;

    sprite_mover #(
      .SPRITE_SIZE(SPRITE_SIZE),
      .INIT_LEFT  (10'(32 + 96 * i)),
      .INIT_TOP   (10'(32 + 64 * i)),
      .INIT_DY_POS(1'(i % 2))
    ) u_mover (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .left    (left[i]),
      .top     (top[i]),
      .edge_hit(hit[i])
    );

    assign off_x = hpos - left[i];
    assign off_y = vpos - top[i];
    assign in_s0[i] = (off_x[9:AW] == '0) && (off_y[9:AW] == '0);
    assign sprite_addr[i*2*AW +: 2*AW] = {off_y[AW-1:0], off_x[AW-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vpos    <= '0;
      bounce_count <= '0;
      scroll       <= '0;
      mode         <= BG_SOLID;
      solid        <= '1;
    end else begin
      prev_vpos <= vpos;
      if (tick) scroll <= scroll + 10'd1;
      // one count per tick no matter how many sprites hit
      if (tick && (hit != '0))
        bounce_count <= (bounce_count == 4'd10) ? 4'd0 : bounce_count + 4'd1;
      unique case (op)
        OP_SOLID: solid <= CW'(vga_control[5:0]);
        OP_HOLD:  ;
        OP_MODE:  mode <= vga_control[3:0];
        OP_AUTO:  mode <= bounce_count;
      endcase
    end
  end

  always_comb begin
    sx = hpos + scroll;
    sy = vpos + scroll;
    if (mode == BG_SX_SUB || mode == BG_XY_SX_SUB || mode == BG_XY_SUB)
      sx = hpos - scroll;
    if (mode == BG_SY_SUB || mode == BG_XY_SY_SUB || mode == BG_XY_SUB)
      sy = vpos - scroll;
    coord = '0;
    lsb = 1'b0;
    use_solid = 1'b0;
    case (mode)
      BG_HSTRIPE: begin
        coord = hpos;
        lsb = vpos[1];
      end
      BG_VSTRIPE: begin
        coord = vpos;
        lsb = hpos[1];
      end
      BG_SX_ADD, BG_SX_SUB: begin
        coord = sx;
        lsb = vpos[2];
      end
      BG_SY_ADD, BG_SY_SUB: begin
        coord = sy;
        lsb = vpos[2];
      end
      BG_XY_ADD, BG_XY_SX_SUB, BG_XY_SY_SUB, BG_XY_SUB: begin
        coord = sy;
        lsb = sx[2];
      end
      BG_SOLID: use_solid = 1'b1;
      default:  use_solid = 1'b1;
    endcase
    bg = solid;
    // channel c MSB from coord bit 5+c, lower bits replicate lsb
    if (!use_solid) begin
      for (int c = 0; c < 3; c++) begin
        for (int b = 0; b < COLOR_BITS; b++) begin
          bg[(2-c)*COLOR_BITS + b] =
            (b == COLOR_BITS - 1) ? coord[5+c] : lsb;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_s1  <= '0;
      vis_s1 <= 1'b0;
      bg_s1  <= '0;
    end else begin
      in_s1  <= in_s0;
      vis_s1 <= visible;
      bg_s1  <= bg;
    end
  end

  // walk from lowest priority up so sprite 0 wins
  always_comb begin
    pix = bg_s1;
    opaque = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      opaque[i] = in_s1[i] && (sprite_rgb[i*CW +: CW] != TRANSPARENT);
      if (opaque[i]) pix = sprite_rgb[i*CW +: CW];
    end
    if (!vis_s1) pix = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) {R, G, B} <= '0;
    else     {R, G, B} <= pix;
  end

`ifdef SPRITE_COLLIDE_EN
  logic multi;
  assign multi = vis_s1 &&
    ((opaque & (opaque - NUM_SPRITES'(1))) != '0);

  always_ff @(posedge clk) begin
    if (rst)        collision <= 1'b0;
    else if (multi) collision <= 1'b1;
    else if (tick)  collision <= 1'b0;
  end
`endif

endmodule
